apb_master_arbiter: RTL and testbench

//  Shares the single APB master port between two requesters (m0: instruction fetch, m1: load/store).

---
 rtl/apb_master_arbiter_pkg.sv | 22 ++
 rtl/apb_master_arbiter_rr_picker.sv | 32 +++
 rtl/apb_master_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// ============================================================================
// Module     : apb_arb_pkg
// Description: Shared FSM encoding and master index constants for the
//              two-requester APB master arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage : apb_arb_pkg

`default_nettype wire

// File: rtl/apb_master_arbiter_rr_picker.sv
// ============================================================================
// Module     : apb_rr_picker
// Description: Combinational two-way grant picker, round-robin or fixed
//              priority (m0 wins ties) selected by ROUND_ROBIN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_grant
);

    always_comb begin
        o_grant = M0;
        if (i_req0 && i_req1) begin
            // On a tie the master that was not served last goes first
            o_grant = (ROUND_ROBIN != 0) ? ~i_last_grant : M0;
        end else if (i_req1) begin
            o_grant = M1;
        end
    end

endmodule : apb_rr_picker

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module     : apb_master_arbiter
// Description: Shares one APB master port between m0 (fetch) and m1
//              (load/store); optional ACCESS timeout via APB_ARB_TIMEOUT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_write,
    input  logic [3:0]            m0_strb,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_write,
    input  logic [3:0]            m1_strb,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic [3:0]            pstb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic [3:0]            r_pstb;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_m0_done;
    logic                  r_m1_done;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;
    logic                  r_m0_err;
    logic                  r_m1_err;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_pick;
    logic                  w_pick_write;
    logic                  w_grant_en;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A master being acknowledged this cycle may still hold req; skip it
    assign w_elig0 = m0_req & ~r_m0_done;
    assign w_elig1 = m1_req & ~r_m1_done;

    apb_rr_picker #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_picker (
        .i_req0       (w_elig0),
        .i_req1       (w_elig1),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    assign w_pick_write = (w_pick == M1) ? m1_write : m0_write;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_to_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_to_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == ACCESS && !pready) begin
            r_to_cnt <= r_to_cnt + c_cnt_w'(1);
        end
    end

    // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES
    assign w_timeout = (r_state == ACCESS) && !pready &&
                       (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    assign w_err   = perr | w_timeout;
    assign w_rdata = (!r_pwrite && !w_err) ? prdata : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_state_nxt = SETUP;
                    w_grant_en  = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready || w_timeout) begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pdata      <= '0;
            r_pstb       <= 4'b0;
            r_grant      <= M0;
            r_last_grant <= M1;
            r_m0_done    <= 1'b0;
            r_m1_done    <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
        end else begin
            r_m0_done  <= 1'b0;
            r_m1_done  <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_err   <= 1'b0;
            r_m1_err   <= 1'b0;
            if (w_grant_en) begin
                r_psel       <= 1'b1;
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
                r_pwrite     <= w_pick_write;
                r_paddr      <= (w_pick == M1) ? m1_addr  : m0_addr;
                r_pdata      <= (w_pick == M1) ? m1_wdata : m0_wdata;
                r_pstb       <= w_pick_write ? ((w_pick == M1) ? m1_strb : m0_strb) : 4'b0;
            end
            if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end
            if (w_complete) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
                if (r_grant == M1) begin
                    r_m1_done  <= 1'b1;
                    r_m1_err   <= w_err;
                    r_m1_rdata <= w_rdata;
                end else begin
                    r_m0_done  <= 1'b1;
                    r_m0_err   <= w_err;
                    r_m0_rdata <= w_rdata;
                end
            end
        end
    end

    assign psel     = r_psel;
    assign penable  = r_penable;
    assign pwrite   = r_pwrite;
    assign paddr    = r_paddr;
    assign pdata    = r_pdata;
    assign pstb     = r_pstb;
    assign m0_done  = r_m0_done;
    assign m1_done  = r_m1_done;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign m0_err   = r_m0_err;
    assign m1_err   = r_m1_err;

endmodule : apb_master_arbiter

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// Module     : tb_apb_master_arbiter
// Description: Scoreboard bench for apb_master_arbiter with a randomised APB
//              slave and a transfer-order reference model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

    localparam int RR = 1;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 0;
`endif

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [3:0]  strb;
    } xfer_t;

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } done_t;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        m0_req, m1_req, m0_write, m1_write;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pdata, prdata;
    logic [3:0]  pstb;
    logic        pready, perr;

    apb_master_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .ROUND_ROBIN    (RR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk     (pclk),     .presetn  (presetn),
        .m0_req   (m0_req),   .m0_addr  (m0_addr),  .m0_wdata (m0_wdata),
        .m0_write (m0_write), .m0_strb  (m0_strb),  .m0_done  (m0_done),
        .m0_rdata (m0_rdata), .m0_err   (m0_err),
        .m1_req   (m1_req),   .m1_addr  (m1_addr),  .m1_wdata (m1_wdata),
        .m1_write (m1_write), .m1_strb  (m1_strb),  .m1_done  (m1_done),
        .m1_rdata (m1_rdata), .m1_err   (m1_err),
        .psel     (psel),     .penable  (penable),  .pwrite   (pwrite),
        .paddr    (paddr),    .pdata    (pdata),    .pstb     (pstb),
        .prdata   (prdata),   .pready   (pready),   .perr     (perr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Expected transfers in grant order, and expected completions
    xfer_t issue_q[$];
    done_t done_q[$];
    logic  lg;

    // Slave response configuration: negative values mean random
    int          cfg_wait = -1;
    int          cfg_err  = -1;
    logic        cfg_fix  = 1'b0;
    logic [31:0] cfg_prdata = 32'h0;
    int          wait_left = 0;

    always begin : p_slave
        @(negedge pclk);
        #1;
        if (!presetn) begin
            wait_left = 0;
            pready    = 1'b0;
            perr      = 1'b0;
            prdata    = 32'h0;
        end else if (psel && !penable) begin
            wait_left = (cfg_wait >= 0) ? cfg_wait : $urandom_range(0, 3);
            pready    = 1'($urandom_range(0, 1));
            perr      = 1'($urandom_range(0, 1));
            prdata    = $urandom;
        end else if (psel && penable && wait_left == 0) begin
            pready = 1'b1;
            perr   = (cfg_err >= 0) ? (cfg_err != 0) : ($urandom_range(0, 3) == 0);
            prdata = cfg_fix ? cfg_prdata : $urandom;
        end else begin
            if (psel && penable) wait_left--;
            pready = (psel && penable) ? 1'b0 : 1'($urandom_range(0, 1));
            perr   = 1'($urandom_range(0, 1));
            prdata = $urandom;
        end
    end

    xfer_t cur;
    logic  cur_valid = 1'b0;
    int    acc_cnt = 0;
    int    setup_cyc = 0, acc1_cyc = 0, done_cyc = 0;

    task automatic chk_apb(input string ph);
        chk({ph, "_paddr"}, paddr, cur.addr);
        chk({ph, "_pwrite"}, {31'b0, pwrite}, {31'b0, cur.write});
        chk({ph, "_pstb"}, {28'b0, pstb}, {28'b0, cur.write ? cur.strb : 4'b0});
        if (cur.write) chk({ph, "_pdata"}, pdata, cur.wdata);
    endtask

    always begin : p_monitor
        done_t e;
        @(negedge pclk);
        #2;
        if (!presetn) begin
            cur_valid = 1'b0;
            issue_q.delete();
            done_q.delete();
        end else begin
            if (psel && !penable) begin
                setup_cyc = cyc;
                if (issue_q.size() == 0) begin
                    bad("unexpected_setup");
                end else begin
                    cur       = issue_q.pop_front();
                    cur_valid = 1'b1;
                    acc_cnt   = 0;
                    chk_apb("setup");
                end
            end else if (psel && penable) begin
                if (!cur_valid) begin
                    bad("access_without_transfer");
                end else begin
                    acc_cnt++;
                    if (acc_cnt == 1) acc1_cyc = cyc;
                    chk_apb("access");
                    if (pready) begin
                        e.m     = cur.m;
                        e.err   = perr;
                        e.rdata = (!cur.write && !perr) ? prdata : 32'h0;
                        e.cyc   = cyc + 1;
                        done_q.push_back(e);
                        cur_valid = 1'b0;
                    end else if (TB_TO != 0 && acc_cnt == TB_TO) begin
                        e.m     = cur.m;
                        e.err   = 1'b1;
                        e.rdata = 32'h0;
                        e.cyc   = cyc + 1;
                        done_q.push_back(e);
                        cur_valid = 1'b0;
                    end
                end
            end
            if (m0_done || m1_done) begin
                done_cyc = cyc;
                if (done_q.size() == 0) begin
                    bad("unexpected_done");
                end else begin
                    e = done_q.pop_front();
                    chk("done_master", {31'b0, m1_done}, {31'b0, e.m});
                    chk("done_both", {31'b0, m0_done & m1_done}, 32'h0);
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_err", {31'b0, e.m ? m1_err : m0_err}, {31'b0, e.err});
                    chk("done_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    chk("psel_at_done", {31'b0, psel}, 32'h0);
                end
            end else if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
                bad("missing_done");
                void'(done_q.pop_front());
            end
        end
    end

    function automatic xfer_t mk_x(input logic m, input logic [31:0] a, input logic [31:0] d,
                                   input logic w, input logic [3:0] s);
        xfer_t x;
        x.m = m; x.addr = a; x.wdata = d; x.write = w; x.strb = s;
        return x;
    endfunction

    function automatic xfer_t rnd_x(input logic m);
        return mk_x(m, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endfunction

    // Reference order: lone requester wins; on a tie the one not served last goes first
    task automatic start_round(input logic en0, input logic en1, input xfer_t x0,
                               input xfer_t x1, output int t0);
        @(negedge pclk);
        #1;
        if (en0 && en1) begin
            if (RR == 0 || lg == 1'b1) begin
                issue_q.push_back(x0); issue_q.push_back(x1); lg = 1'b1;
            end else begin
                issue_q.push_back(x1); issue_q.push_back(x0); lg = 1'b0;
            end
        end else if (en0) begin
            issue_q.push_back(x0); lg = 1'b0;
        end else if (en1) begin
            issue_q.push_back(x1); lg = 1'b1;
        end
        if (en0) begin
            m0_addr = x0.addr; m0_wdata = x0.wdata; m0_write = x0.write; m0_strb = x0.strb; m0_req = 1'b1;
        end
        if (en1) begin
            m1_addr = x1.addr; m1_wdata = x1.wdata; m1_write = x1.write; m1_strb = x1.strb; m1_req = 1'b1;
        end
        t0 = cyc;
    endtask

    // Each master keeps req high through its done cycle, then drops it
    task automatic finish_round(input logic en0, input logic en1);
        logic d0, d1, f0, f1;
        int   n;
        d0 = !en0; d1 = !en1; f0 = 1'b0; f1 = 1'b0; n = 0;
        while (!(d0 && d1) && n < 200) begin
            @(negedge pclk);
            #1;
            n++;
            if (f0) begin m0_req = 1'b0; m0_addr = $urandom; m0_wdata = $urandom; d0 = 1'b1; f0 = 1'b0; end
            if (f1) begin m1_req = 1'b0; m1_addr = $urandom; m1_wdata = $urandom; d1 = 1'b1; f1 = 1'b0; end
            if (m0_done && !d0) f0 = 1'b1;
            if (m1_done && !d1) f1 = 1'b1;
        end
        if (!(d0 && d1)) begin
            bad("round_timeout");
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge pclk);
        #1;
        presetn = 1'b0;
        #1;
        chk("reset_async_psel", {31'b0, psel}, 32'h0);
        chk("reset_async_penable", {31'b0, penable}, 32'h0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge pclk);
        #1;
        presetn = 1'b1;
        lg = 1'b1;
    endtask

    task automatic wait_access(input string nm);
        int n;
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge pclk);
            #1;
            n++;
        end
        if (!(psel && penable)) bad(nm);
    endtask

    initial begin : p_stim
        int    t0;
        xfer_t x0, x1;
        presetn = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_strb = '0; m1_strb = '0;
        lg = 1'b1;
        repeat (3) @(negedge pclk);
        #2;
        chk("rst_psel", {31'b0, psel}, 32'h0);
        chk("rst_penable", {31'b0, penable}, 32'h0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pdata", pdata, 32'h0);
        chk("rst_pstb", {28'b0, pstb}, 32'h0);
        chk("rst_m0_done", {31'b0, m0_done}, 32'h0);
        chk("rst_m1_done", {31'b0, m1_done}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_m0_err", {31'b0, m0_err}, 32'h0);
        chk("rst_m1_err", {31'b0, m1_err}, 32'h0);
        @(negedge pclk);
        #1;
        presetn = 1'b1;

        // Single write with zero wait: psel +1, penable +2, done +3
        cfg_wait = 0; cfg_err = 0;
        x0 = mk_x(1'b0, 32'h1000_0000, 32'h0000_00A5, 1'b1, 4'hF);
        start_round(1'b1, 1'b0, x0, x0, t0);
        finish_round(1'b1, 1'b0);
        chk("lat_setup", setup_cyc, t0 + 1);
        chk("lat_access", acc1_cyc, t0 + 2);
        chk("lat_done", done_cyc, t0 + 3);

        // Simultaneous requests, repeated; then m0 alone flips the tie-break
        cfg_wait = -1; cfg_err = -1;
        repeat (2) begin
            start_round(1'b1, 1'b1, rnd_x(1'b0), rnd_x(1'b1), t0);
            finish_round(1'b1, 1'b1);
        end
        start_round(1'b1, 1'b0, rnd_x(1'b0), rnd_x(1'b1), t0);
        finish_round(1'b1, 1'b0);
        start_round(1'b1, 1'b1, rnd_x(1'b0), rnd_x(1'b1), t0);
        finish_round(1'b1, 1'b1);

        // m1 read with four stall cycles
        cfg_wait = 4; cfg_err = 0; cfg_fix = 1'b1; cfg_prdata = 32'hDEAD_BEEF;
        x1 = mk_x(1'b1, 32'h8000_0000, 32'h1234_5678, 1'b0, 4'hF);
        start_round(1'b0, 1'b1, x1, x1, t0);
        finish_round(1'b0, 1'b1);
        chk("stall_done_offset", done_cyc - acc1_cyc, 5);

        // m0 read answered with an error
        cfg_wait = 0; cfg_err = 1;
        x0 = mk_x(1'b0, 32'h3000_0000, 32'h0, 1'b0, 4'h3);
        start_round(1'b1, 1'b0, x0, x0, t0);
        finish_round(1'b1, 1'b0);
        cfg_fix = 1'b0; cfg_wait = -1; cfg_err = -1;

        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(0, 2);
            start_round(pat != 1, pat != 0, rnd_x(1'b0), rnd_x(1'b1), t0);
            finish_round(pat != 1, pat != 0);
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        // Reset during ACCESS: transfer is lost, m0 wins the following tie
        cfg_wait = 20;
        start_round(1'b1, 1'b1, rnd_x(1'b0), rnd_x(1'b1), t0);
        wait_access("reset_test_no_access");
        pulse_reset();
        cfg_wait = -1;
        repeat (2) @(negedge pclk);
        start_round(1'b1, 1'b1, rnd_x(1'b0), rnd_x(1'b1), t0);
        finish_round(1'b1, 1'b1);

        // Slave never answers
        cfg_wait = 1000;
        x0 = mk_x(1'b0, 32'h4000_0000, 32'h0, 1'b0, 4'hF);
        start_round(1'b1, 1'b0, x0, x0, t0);
`ifdef APB_ARB_TIMEOUT_EN
        finish_round(1'b1, 1'b0);
        chk("timeout_done_offset", done_cyc - acc1_cyc, TB_TO);
`else
        repeat (40) @(negedge pclk);
        #1;
        chk("stuck_psel", {31'b0, psel}, 32'h1);
        chk("stuck_penable", {31'b0, penable}, 32'h1);
        pulse_reset();
`endif
        cfg_wait = -1;

        repeat (6) @(negedge pclk);
        #3;
        chk("issue_q_drained", issue_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_master_arbiter

`default_nettype wire
